// File: rtl/simon_round_engine.sv
// ---------------------------------------------------------------------------
// simon_round_engine
//   Iterative SIMON block cipher datapath, one round per clock. Encrypts or
//   decrypts one block per transaction using an externally expanded key
//   schedule (simon_kexp), read by index through rk_idx/rk.
//   Modes: 64/128 (32-bit words, 44 rounds), 128/128 (64-bit words, 68 rounds).
//
// Ports
//   ck         clock, all state on posedge
//   nrst       synchronous active-low reset
//   mode       0 = 64/128, 1 = 128/128; sampled on accept
//   dir        0 = encrypt, 1 = decrypt; sampled on accept
//   exp_valid  key schedule complete; gates acceptance only
//   d_data     input block {x, y}; in 64/128 only [63:0] is used
//   d_valid    input block valid
//   d_ready    engine idle and key schedule valid
//   rk_idx     round-key index requested this cycle (0 outside RUN)
//   rk         round key for rk_idx, same-cycle combinational lookup
//   o_data     result block, same layout as d_data, held through DONE
//   o_valid    result valid
//   o_ready    downstream accepts result
//   busy       high while rounds are being applied
// ---------------------------------------------------------------------------
module simon_round_engine #(
    parameter int SIMON_MAX_ROUNDS     = 68,
    parameter int SIMON_MAX_WORD_WIDTH = 64,
    parameter int SIMON_BLOCK_WIDTH    = 128
) (
    input  logic                            ck,
    input  logic                            nrst,
    input  logic                            mode,
    input  logic                            dir,
    input  logic                            exp_valid,
    input  logic [SIMON_BLOCK_WIDTH-1:0]    d_data,
    input  logic                            d_valid,
    output logic                            d_ready,
    output logic [$clog2(SIMON_MAX_ROUNDS)-1:0] rk_idx,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] rk,
    output logic [SIMON_BLOCK_WIDTH-1:0]    o_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic                            busy
);

    localparam int WW = SIMON_MAX_WORD_WIDTH;
    localparam int HW = WW / 2;
    localparam int IW = $clog2(SIMON_MAX_ROUNDS);

    localparam logic SIMON_MODE_64_128  = 1'b0;
    localparam logic SIMON_MODE_128_128 = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       r_state;
    logic                         r_mode;
    logic                         r_dir;
    logic [WW-1:0]                r_x;
    logic [WW-1:0]                r_y;
    logic [IW-1:0]                r_rnd;
    logic [SIMON_BLOCK_WIDTH-1:0] r_odata;
    logic                         r_ovalid;

    logic [IW-1:0]                w_tm1;
    logic [WW-1:0]                w_fin;
    logic [WW-1:0]                w_oth;
    logic [HW-1:0]                w_f32;
    logic [WW-1:0]                w_f64;
    logic [WW-1:0]                w_f;
    logic [WW-1:0]                w_k;
    logic [WW-1:0]                w_t;
    logic [WW-1:0]                w_xn;
    logic [WW-1:0]                w_yn;
    logic [SIMON_BLOCK_WIDTH-1:0] w_res;

    // Last round index T-1 for the latched mode
    assign w_tm1 = (r_mode == SIMON_MODE_128_128) ? IW'(SIMON_MAX_ROUNDS - 1) : IW'(43);

    // Encrypt mixes f(x) into y; decrypt mixes f(y) into x. Selecting the
    // operands up front lets one f() instance serve both directions.
    assign w_fin = r_dir ? r_y : r_x;
    assign w_oth = r_dir ? r_x : r_y;

    assign w_f32 = ({w_fin[HW-2:0], w_fin[HW-1]} & {w_fin[HW-9:0], w_fin[HW-1:HW-8]})
                 ^  {w_fin[HW-3:0], w_fin[HW-1:HW-2]};
    assign w_f64 = ({w_fin[WW-2:0], w_fin[WW-1]} & {w_fin[WW-9:0], w_fin[WW-1:WW-8]})
                 ^  {w_fin[WW-3:0], w_fin[WW-1:WW-2]};

    // In 32-bit mode the upper halves of x/y are held at zero, so masking
    // f and the key keeps the whole datapath 32-bit clean.
    assign w_f = r_mode ? w_f64 : {{HW{1'b0}}, w_f32};
    assign w_k = r_mode ? rk    : {{HW{1'b0}}, rk[HW-1:0]};
    assign w_t = w_oth ^ w_f ^ w_k;

    assign w_xn = r_dir ? r_y : w_t;
    assign w_yn = r_dir ? w_t : r_x;

    assign w_res = r_mode ? {w_xn, w_yn}
                          : {{WW{1'b0}}, w_xn[HW-1:0], w_yn[HW-1:0]};

    assign d_ready = (r_state == S_IDLE) & exp_valid;
    assign busy    = (r_state == S_RUN);
    assign rk_idx  = busy ? (r_dir ? (w_tm1 - r_rnd) : r_rnd) : '0;
    assign o_data  = r_odata;
    assign o_valid = r_ovalid;

    always_ff @(posedge ck) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_mode   <= SIMON_MODE_64_128;
            r_dir    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_rnd    <= '0;
            r_odata  <= '0;
            r_ovalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_valid && exp_valid) begin
                        r_mode  <= mode;
                        r_dir   <= dir;
                        r_x     <= mode ? d_data[2*WW-1:WW] : {{HW{1'b0}}, d_data[WW-1:HW]};
                        r_y     <= mode ? d_data[WW-1:0]    : {{HW{1'b0}}, d_data[HW-1:0]};
                        r_rnd   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x   <= w_xn;
                    r_y   <= w_yn;
                    r_rnd <= r_rnd + 1'b1;
                    if (r_rnd == w_tm1) begin
                        r_odata  <= w_res;
                        r_ovalid <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        r_ovalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_engine.sv
// ---------------------------------------------------------------------------
// tb_simon_round_engine
//   Scoreboard bench for simon_round_engine. The bench expands both key
//   schedules itself, serves rk from them, and pushes each expected result
//   when the block is accepted; a negedge monitor pops and compares on every
//   output handshake.
// ---------------------------------------------------------------------------
module tb_simon_round_engine;

    logic         ck = 1'b0;
    logic         nrst;
    logic         mode;
    logic         dir;
    logic         exp_valid;
    logic [127:0] d_data;
    logic         d_valid;
    logic         d_ready;
    logic [6:0]   rk_idx;
    logic [63:0]  rk;
    logic [127:0] o_data;
    logic         o_valid;
    logic         o_ready;
    logic         busy;

    simon_round_engine dut (
        .ck(ck), .nrst(nrst), .mode(mode), .dir(dir), .exp_valid(exp_valid),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
        .rk_idx(rk_idx), .rk(rk),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .busy(busy)
    );

    always #5 ck = ~ck;

    int n_chk = 0;
    int n_err = 0;
    int n_sent = 0;
    int n_rcv = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [127:0] q[$];
    logic         kmode = 1'b0;
    logic         rnd_ordy = 1'b0;

    logic [31:0]  ks32[68];
    logic [63:0]  ks64[68];
    logic [61:0]  z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    logic [61:0]  z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    always @(posedge ck) cyc++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] f32(input logic [31:0] v);
        return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
    endfunction

    function automatic logic [63:0] f64(input logic [63:0] v);
        return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
    endfunction

    function automatic logic [127:0] model(input logic m, input logic d, input logic [127:0] din);
        logic [63:0] x, y, t;
        if (!m) begin
            x = {32'b0, din[63:32]};
            y = {32'b0, din[31:0]};
            for (int i = 0; i < 44; i++) begin
                if (!d) begin t = x; x = {32'b0, y[31:0] ^ f32(x[31:0]) ^ ks32[i]}; y = t; end
                else    begin t = y; y = {32'b0, x[31:0] ^ f32(y[31:0]) ^ ks32[43-i]}; x = t; end
            end
            return {64'b0, x[31:0], y[31:0]};
        end
        x = din[127:64];
        y = din[63:0];
        for (int i = 0; i < 68; i++) begin
            if (!d) begin t = x; x = y ^ f64(x) ^ ks64[i]; y = t; end
            else    begin t = y; y = x ^ f64(y) ^ ks64[67-i]; x = t; end
        end
        return {x, y};
    endfunction

    task automatic expand_keys();
        logic [31:0] t32;
        logic [63:0] t64;
        ks32[0] = 32'h03020100; ks32[1] = 32'h0b0a0908;
        ks32[2] = 32'h13121110; ks32[3] = 32'h1b1a1918;
        for (int i = 4; i < 68; i++) begin
            t32 = {ks32[i-1][2:0], ks32[i-1][31:3]} ^ ks32[i-3];
            t32 = t32 ^ {t32[0], t32[31:1]};
            ks32[i] = ~ks32[i-4] ^ t32 ^ {31'b0, z3[61 - ((i-4) % 62)]} ^ 32'd3;
        end
        ks64[0] = 64'h0706050403020100; ks64[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 2; i < 68; i++) begin
            t64 = {ks64[i-1][2:0], ks64[i-1][63:3]};
            t64 = t64 ^ {t64[0], t64[63:1]};
            ks64[i] = ~ks64[i-2] ^ t64 ^ {63'b0, z2[61 - ((i-2) % 62)]} ^ 64'd3;
        end
    endtask

    // Key table lookup, served for the mode of the block in flight
    always_comb begin
        rk = '0;
        if (rk_idx < 7'd68) rk = kmode ? ks64[rk_idx] : {32'b0, ks32[rk_idx]};
    end

    always @(posedge ck) if (rnd_ordy) begin #1; o_ready = 1'($urandom_range(0, 1)); end

    // ---------------- output monitor ----------------
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;

    always @(negedge ck) begin
        if (!nrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", o_valid, 1'b1);
                chk("stall_hold", o_data, prev_data);
            end
            if (busy || o_valid) chk("drdy_busy", d_ready, 1'b0);
            if (busy) chk("idx_range", rk_idx <= (kmode ? 7'd67 : 7'd43), 1'b1);
            else      chk("idx_idle", rk_idx, 7'd0);
            if (o_valid && o_ready) begin
                chk("q_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    chk("sb_data", o_data, q.pop_front());
                    n_rcv++;
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic m, input logic d, input logic [127:0] din,
                        input logic push, input logic [127:0] expv);
        logic acc = 1'b0;
        @(posedge ck); #1;
        mode = m; dir = d; d_data = din; d_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge ck);
            if (d_ready) begin acc = 1'b1; break; end
        end
        chk("accept_to", acc, 1'b1);
        if (acc) begin
            kmode = m;
            if (push) begin q.push_back(expv); n_sent++; end
        end
        @(posedge ck); #1;
        acc_cyc = cyc;
        d_valid = 1'b0;
        mode = ~m; dir = ~d;
        d_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called right after the accept edge: checks index order and latency
    task automatic run_chk(input logic m, input logic d);
        int t = m ? 68 : 44;
        chk("busy_run", busy, 1'b1);
        chk("rk_first", rk_idx, d ? 7'(t-1) : 7'd0);
        repeat (t-1) begin @(posedge ck); #1; end
        chk("rk_last", rk_idx, d ? 7'd0 : 7'(t-1));
        chk("vld_early", o_valid, 1'b0);
        @(posedge ck); #1;
        chk("vld_lat", o_valid, 1'b1);
        chk("busy_done", busy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(posedge ck); #1;
            if (q.size() == 0 && !o_valid && !busy) break;
        end
        chk("drain", 128'(q.size()), 128'd0);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] PT64  = {64'h0123456789abcdef, 64'h656b696c20646e75};
    localparam logic [127:0] CT64  = {64'h0, 64'h44c8fc20b9dfa07a};
    localparam logic [127:0] PT128 = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] CT128 = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

    initial begin
        logic [127:0] blk;
        logic [127:0] stall_exp;
        int acc_b;
        nrst = 1'b0; mode = 1'b0; dir = 1'b0; exp_valid = 1'b0;
        d_data = '0; d_valid = 1'b0; o_ready = 1'b1;
        expand_keys();

        repeat (3) @(posedge ck);
        #1;
        chk("rst_ovalid", o_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_odata", o_data, 128'd0);
        chk("rst_rkidx", rk_idx, 7'd0);
        chk("rst_drdy", d_ready, 1'b0);
        nrst = 1'b1; exp_valid = 1'b1;

        chk("model64", model(1'b0, 1'b0, PT64), CT64);
        chk("model128", model(1'b1, 1'b0, PT128), CT128);

        // Known-answer encrypt, upper half of the 64/128 input is junk
        send(1'b0, 1'b0, PT64, 1'b1, CT64);   run_chk(1'b0, 1'b0);
        send(1'b1, 1'b0, PT128, 1'b1, CT128); run_chk(1'b1, 1'b0);

        // Known-answer decrypt, reverse key order
        send(1'b0, 1'b1, {64'hfedcba9876543210, CT64[63:0]}, 1'b1, {64'h0, PT64[63:0]});
        run_chk(1'b0, 1'b1);
        send(1'b1, 1'b1, CT128, 1'b1, PT128); run_chk(1'b1, 1'b1);
        drain();

        // No accept without a complete key schedule
        exp_valid = 1'b0;
        @(posedge ck); #1;
        d_valid = 1'b1;
        repeat (4) begin @(negedge ck); chk("drdy_noexp", d_ready, 1'b0); end
        @(posedge ck); #1;
        chk("no_accept", busy, 1'b0);
        d_valid = 1'b0; exp_valid = 1'b1;

        // Stall in DONE with o_ready low
        o_ready = 1'b0;
        blk = {$urandom, $urandom, $urandom, $urandom};
        stall_exp = model(1'b0, 1'b0, blk);
        send(1'b0, 1'b0, blk, 1'b1, stall_exp);
        repeat (44) begin @(posedge ck); #1; end
        chk("stall_rise", o_valid, 1'b1);
        repeat (10) begin
            @(posedge ck); #1;
            chk("stall_ovalid", o_valid, 1'b1);
            chk("stall_drdy", d_ready, 1'b0);
            chk("stall_data", o_data, stall_exp);
        end
        o_ready = 1'b1;

        // Back-to-back blocks: minimum interval is T+2
        blk = {$urandom, $urandom, $urandom, $urandom};
        send(1'b0, 1'b1, blk, 1'b1, model(1'b0, 1'b1, blk));
        acc_b = acc_cyc;
        blk = {$urandom, $urandom, $urandom, $urandom};
        send(1'b0, 1'b0, blk, 1'b1, model(1'b0, 1'b0, blk));
        chk("interval", 128'(acc_cyc - acc_b), 128'd46);
        drain();

        // Reset in the middle of RUN discards the block
        send(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        repeat (20) begin @(posedge ck); #1; end
        chk("mid_busy", busy, 1'b1);
        nrst = 1'b0;
        @(posedge ck); #1;
        nrst = 1'b1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ovalid", o_valid, 1'b0);
        chk("mrst_odata", o_data, 128'd0);
        chk("mrst_rkidx", rk_idx, 7'd0);
        chk("mrst_drdy", d_ready, 1'b1);
        blk = {$urandom, $urandom, $urandom, $urandom};
        send(1'b1, 1'b1, blk, 1'b1, model(1'b1, 1'b1, blk));
        run_chk(1'b1, 1'b1);
        drain();

        // Random blocks, alternating mode and dir, random back-pressure
        rnd_ordy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic m, d;
            m = 1'(i % 2);
            d = 1'((i / 2) % 2);
            blk = {$urandom, $urandom, $urandom, $urandom};
            send(m, d, blk, 1'b1, model(m, d, blk));
        end
        drain();
        rnd_ordy = 1'b0;
        @(posedge ck); #1;
        o_ready = 1'b1;
        chk("sent_rcvd", 128'(n_rcv), 128'(n_sent));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
